// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg : shared types and codes for the comparator statistics path
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam logic [1:0] MAJ_NONE = 2'b00;
  localparam logic [1:0] MAJ_EQ   = 2'b01;
  localparam logic [1:0] MAJ_GT   = 2'b10;
  localparam logic [1:0] MAJ_LT   = 2'b11;

  // Flag order is {eq, greater, less}
  localparam logic [2:0] FLG_EQ = 3'b100;
  localparam logic [2:0] FLG_GT = 3'b010;
  localparam logic [2:0] FLG_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/cmp_majority.sv
// ----------------------------------------------------------------------------
// cmp_majority : strict-winner code from three class counts (ties give none)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_majority
  import cmp_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] i_eq_cnt,
  input  logic [CNT_W-1:0] i_gt_cnt,
  input  logic [CNT_W-1:0] i_lt_cnt,
  output logic [1:0]       o_majority
);

  always_comb begin
    o_majority = MAJ_NONE;
    if ((i_eq_cnt > i_gt_cnt) && (i_eq_cnt > i_lt_cnt)) begin
      o_majority = MAJ_EQ;
    end else if ((i_gt_cnt > i_eq_cnt) && (i_gt_cnt > i_lt_cnt)) begin
      o_majority = MAJ_GT;
    end else if ((i_lt_cnt > i_eq_cnt) && (i_lt_cnt > i_gt_cnt)) begin
      o_majority = MAJ_LT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmp_window_stats.sv
// ----------------------------------------------------------------------------
// cmp_window_stats : per-window eq/gt/lt/error counts with held summary output
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_window_stats
  import cmp_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eq,
  input  logic             greater,
  input  logic             less,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       majority
);

  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_eq_w, r_gt_w, r_lt_w, r_err_w, r_idx;
  logic [CNT_W-1:0] r_eq_o, r_gt_o, r_lt_o, r_err_o;
  logic [1:0]       r_maj;

  logic [2:0]       w_flags;
  logic             w_is_eq, w_is_gt, w_is_lt, w_is_err;
  logic             w_accept, w_last;
  logic [CNT_W-1:0] w_eq_nxt, w_gt_nxt, w_lt_nxt, w_err_nxt;
  logic [1:0]       w_maj;

  assign w_flags  = {eq, greater, less};
  assign w_is_eq  = (w_flags == FLG_EQ);
  assign w_is_gt  = (w_flags == FLG_GT);
  assign w_is_lt  = (w_flags == FLG_LT);
  assign w_is_err = ~(w_is_eq | w_is_gt | w_is_lt);

  assign w_accept = in_valid && (r_state == ACCUM);
  assign w_last   = (r_idx == C_LAST);

  // Counts including the sample on the current edge; the final report uses these
  assign w_eq_nxt  = r_eq_w  + {{(CNT_W-1){1'b0}}, w_is_eq};
  assign w_gt_nxt  = r_gt_w  + {{(CNT_W-1){1'b0}}, w_is_gt};
  assign w_lt_nxt  = r_lt_w  + {{(CNT_W-1){1'b0}}, w_is_lt};
  assign w_err_nxt = r_err_w + {{(CNT_W-1){1'b0}}, w_is_err};

  cmp_majority #(.CNT_W(CNT_W)) u_majority (
    .i_eq_cnt   (w_eq_nxt),
    .i_gt_cnt   (w_gt_nxt),
    .i_lt_cnt   (w_lt_nxt),
    .o_majority (w_maj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_eq_w  <= C_ZERO;
      r_gt_w  <= C_ZERO;
      r_lt_w  <= C_ZERO;
      r_err_w <= C_ZERO;
      r_idx   <= C_ZERO;
      r_eq_o  <= C_ZERO;
      r_gt_o  <= C_ZERO;
      r_lt_o  <= C_ZERO;
      r_err_o <= C_ZERO;
      r_maj   <= MAJ_NONE;
    end else if (clear) begin
      r_state <= ACCUM;
      r_eq_w  <= C_ZERO;
      r_gt_w  <= C_ZERO;
      r_lt_w  <= C_ZERO;
      r_err_w <= C_ZERO;
      r_idx   <= C_ZERO;
      r_eq_o  <= C_ZERO;
      r_gt_o  <= C_ZERO;
      r_lt_o  <= C_ZERO;
      r_err_o <= C_ZERO;
      r_maj   <= MAJ_NONE;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_eq_o  <= w_eq_nxt;
              r_gt_o  <= w_gt_nxt;
              r_lt_o  <= w_lt_nxt;
              r_err_o <= w_err_nxt;
              r_maj   <= w_maj;
              r_eq_w  <= C_ZERO;
              r_gt_w  <= C_ZERO;
              r_lt_w  <= C_ZERO;
              r_err_w <= C_ZERO;
              r_idx   <= C_ZERO;
              r_state <= REPORT;
            end else begin
              r_eq_w  <= w_eq_nxt;
              r_gt_w  <= w_gt_nxt;
              r_lt_w  <= w_lt_nxt;
              r_err_w <= w_err_nxt;
              r_idx   <= r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            r_state <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == REPORT);
  assign eq_cnt    = r_eq_o;
  assign gt_cnt    = r_gt_o;
  assign lt_cnt    = r_lt_o;
  assign err_cnt   = r_err_o;
  assign majority  = r_maj;

endmodule

`default_nettype wire

// File: tb/tb_cmp_window_stats.sv
// ----------------------------------------------------------------------------
// tb_cmp_window_stats : directed window vectors plus clear/reset corner cases
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmp_window_stats;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             eq = 1'b0, greater = 1'b0, less = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt, err_cnt;
  logic [1:0]       majority;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cmp_window_stats #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .eq        (eq),
    .greater   (greater),
    .less      (less),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq_cnt    (eq_cnt),
    .gt_cnt    (gt_cnt),
    .lt_cnt    (lt_cnt),
    .err_cnt   (err_cnt),
    .majority  (majority)
  );

  // Eight 3-bit samples {eq,greater,less}, first sample in the top bits
  typedef struct {
    string      name;
    logic [23:0] flags;
    int         gap;
    int         e_eq, e_gt, e_lt, e_err, e_maj;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge in ACCUM; returns at the negedge after the last accept
  task automatic feed(input logic [23:0] flags, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      {eq, greater, less} = flags[23-3*i -: 3];
      @(negedge clk);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_report(input vec_t v);
    check({v.name, " out_valid"}, int'(out_valid), 1);
    check({v.name, " in_ready"},  int'(in_ready),  0);
    check({v.name, " eq_cnt"},    int'(eq_cnt),    v.e_eq);
    check({v.name, " gt_cnt"},    int'(gt_cnt),    v.e_gt);
    check({v.name, " lt_cnt"},    int'(lt_cnt),    v.e_lt);
    check({v.name, " err_cnt"},   int'(err_cnt),   v.e_err);
    check({v.name, " majority"},  int'(majority),  v.e_maj);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " hs out_valid"}, int'(out_valid), 0);
    check({name, " hs in_ready"},  int'(in_ready),  1);
  endtask

  initial begin
    vecs[0] = '{"v0_eq_major",  24'b100_100_100_100_100_010_010_001, 0, 5, 2, 1, 0, 1};
    vecs[1] = '{"v1_gt_lt_tie", 24'b010_010_010_010_001_001_001_001, 0, 0, 4, 4, 0, 0};
    vecs[2] = '{"v2_lt_err",    24'b001_001_001_100_100_110_110_110, 0, 2, 0, 3, 3, 3};
    vecs[3] = '{"v3_gapped",    24'b100_100_100_100_100_010_010_001, 2, 5, 2, 1, 0, 1};
    vecs[4] = '{"v4_err_mix",   24'b000_011_101_111_110_010_010_100, 0, 1, 2, 0, 5, 2};
    vecs[5] = '{"v5_all_eq",    24'b100_100_100_100_100_100_100_100, 0, 8, 0, 0, 0, 1};

    repeat (2) @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset majority",  int'(majority),  0);
    check("reset eq_cnt",    int'(eq_cnt),    0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);

    // Latency: no report before the last sample, report right after it
    feed(vecs[0].flags, 7, 0);
    check("v0 pre-last out_valid", int'(out_valid), 0);
    feed(24'(vecs[0].flags << 21), 1, 0);
    check_report(vecs[0]);

    // Held report ignores in_valid while out_ready is low
    in_valid = 1'b1;
    {eq, greater, less} = 3'b010;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("hold out_valid", int'(out_valid), 1);
    check("hold eq_cnt",    int'(eq_cnt),    5);
    check("hold gt_cnt",    int'(gt_cnt),    2);
    check("hold lt_cnt",    int'(lt_cnt),    1);
    handshake("v0");

    for (int k = 1; k < 5; k++) begin
      feed(vecs[k].flags, WINDOW, vecs[k].gap);
      check_report(vecs[k]);
      handshake(vecs[k].name);
    end

    // clear on the 5th accept: that sample and the four before it are lost
    feed(24'b100_100_100_100_000_000_000_000, 4, 0);
    in_valid = 1'b1;
    {eq, greater, less} = 3'b100;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear5 in_ready",  int'(in_ready),  1);
    check("clear5 out_valid", int'(out_valid), 0);
    check("clear5 eq_cnt",    int'(eq_cnt),    0);
    check("clear5 err_cnt",   int'(err_cnt),   0);
    feed(vecs[2].flags, WINDOW, 0);
    check_report(vecs[2]);

    // clear while reporting drops out_valid without a handshake
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_rep out_valid", int'(out_valid), 0);
    check("clear_rep in_ready",  int'(in_ready),  1);
    check("clear_rep lt_cnt",    int'(lt_cnt),    0);

    // Fill output registers, then reset asynchronously mid-window
    feed(vecs[4].flags, WINDOW, 0);
    check_report(vecs[4]);
    handshake("v4b");
    feed(vecs[0].flags, 3, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async out_valid", int'(out_valid), 0);
    check("async gt_cnt",    int'(gt_cnt),    0);
    check("async err_cnt",   int'(err_cnt),   0);
    check("async majority",  int'(majority),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", int'(in_ready), 1);
    feed(vecs[5].flags, WINDOW, 0);
    check_report(vecs[5]);
    handshake(vecs[5].name);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmp_window_stats.md
Name: cmp_window_stats

Overview:
- Downstream consumer of the 4-bit magnitude comparator's eq/greater/less flags.
- Accepts one flag triple per valid/ready transfer and accumulates per-class counts over a window of WINDOW samples.
- Counts flag triples that are not one-hot as errors.
- At the end of each window, presents a held summary with a valid/ready output handshake. The summary is consumed by the test-result logging stage.

Parameters:
- WINDOW, 8, samples per report window; legal range is 2 or more.
- CNT_W, 4, width of every counter; must satisfy 2**CNT_W > WINDOW.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; highest priority after reset.
- in_valid  in  1  flag triple present.
- in_ready  out  1  block can accept a sample.
- eq  in  1  comparator equal flag.
- greater  in  1  comparator greater flag.
- less  in  1  comparator less flag.
- out_valid  out  1  summary valid.
- out_ready  in  1  downstream accepts summary.
- eq_cnt  out  CNT_W  samples with only eq high.
- gt_cnt  out  CNT_W  samples with only greater high.
- lt_cnt  out  CNT_W  samples with only less high.
- err_cnt  out  CNT_W  samples that are not one-hot (zero or two-plus flags high).
- majority  out  2  strict winner: 00 tie/none, 01 eq, 10 gt, 11 lt.

Behaviour:
- Reset is asynchronous and active-low:
  - State = ACCUM, all working and output counters = 0, sample index = 0.
  - out_valid = 0, majority = 00.
  - in_ready = 1 after reset is released.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - REPORT: in_ready = 0, out_valid = 1.
  - in_ready and out_valid are decoded directly from the state register; no combinational path from any input.
- A sample is accepted on in_valid && in_ready at a rising edge. Classification of {eq, greater, less}:
  - 100 increments working eq count.
  - 010 increments working gt count.
  - 001 increments working lt count.
  - Any other pattern (000, 011, 101, 110, 111) increments working err count.
- The sample index increments per accepted sample.
- Window completion: on the edge that accepts sample number WINDOW (index WINDOW-1):
  - The final counts, including that sample, are loaded into the output registers.
  - majority is computed from those final counts.
  - Working counters and index are zeroed.
  - State becomes REPORT.
  - out_valid is high starting the cycle after the last accepted sample, so latency is 1 cycle.
- majority:
  - A class wins only if its count is strictly greater than both other class counts.
  - Any tie for the maximum gives 00.
  - err_cnt never participates.
- REPORT:
  - Outputs are held stable.
  - in_valid is ignored.
  - On out_valid && out_ready: state becomes ACCUM and out_valid drops the next cycle. Output registers keep their values; they are don't-care while out_valid = 0.
  - A first new sample can be accepted one cycle after the handshake.
- clear:
  - Synchronous; gives the same end state as reset.
  - Takes priority over a simultaneous sample accept or summary handshake; that sample is discarded.
  - Asserted in REPORT, it drops out_valid without the handshake.
- Counters never wrap, guaranteed by the CNT_W constraint. The sum eq_cnt+gt_cnt+lt_cnt+err_cnt equals WINDOW in every report.
- Reset asserted mid-window or mid-report discards all partial data immediately (asynchronous).

Decomposition:
- Shared package cmp_pkg holds:
  - State enum (ACCUM, REPORT).
  - MAJ_NONE=2'b00, MAJ_EQ=2'b01, MAJ_GT=2'b10, MAJ_LT=2'b11.
  - Flag-pattern constants FLG_EQ=3'b100, FLG_GT=3'b010, FLG_LT=3'b001.
- One sub-module is natural: cmp_majority. It is combinational, takes three CNT_W counts and returns the 2-bit majority code. It is reused by the logging stage.

Test Plan (WINDOW=8, CNT_W=4):
- Reset then 8 back-to-back samples: 5×100, 2×010, 1×001 -> out_valid high 1 cycle after the 8th accept; counts 5/2/1/0; majority 01; in_ready 0.
- Window of 4×010, 4×001 -> majority 00 (tie). Window of 3×001, 2×100, 3×110 -> lt_cnt 3, err_cnt 3, majority 11.
- Hold out_ready low for 10 cycles in REPORT while driving in_valid=1 -> outputs unchanged, no sample counted. Raise out_ready -> next window starts from zero counts.
- Gapped in_valid (1 in 3 cycles) -> report contents identical to the back-to-back case for the same sample sequence.
- Assert clear at the same edge as the 5th accept -> that sample is dropped, state is ACCUM with zero counts, and the next 8 accepts form a full window. Assert clear during REPORT -> out_valid is 0 next cycle.
- Drop rst_n asynchronously mid-window (between clock edges) -> out_valid=0 and counts=0 immediately. After release, a fresh 8-sample window reports correctly.
